instr_encoder_writer: RTL
=========================

// Module: instr_encoder_writer
// PURPOSE
//  Encoder counterpart of the main control decoder: packs instruction fields into 32-bit MIPS words.
//  Handles opcodes 0x00 (R-type), 0x08 ADDI, 0x04 BEQ, 0x05 BNE, 0x0d ORI and 0x0f LUI.
//  Words pass through a FIFO and are written sequentially into instruction memory, which is how the
//  CPU testbench loads programs. It sits between the program source and the instruction memory write port.
// PARAMETERS
//  DEPTH   8   FIFO depth in words; power of 2, >= 2
//  CNT_W   16  width of word_cnt_o
// PORTS
//  clk_i        in   1   clock; all state changes on the rising edge
//  rst_i        in   1   reset, asynchronous, active-high
//  start_i      in   1   begin a load session; honoured only in IDLE
//  base_addr_i  in   32  byte address of the first word; sampled when start_i is honoured
//  in_valid_i   in   1   field bundle valid
//  in_ready_o   out  1   bundle accepted when in_valid_i & in_ready_o
//  in_last_i    in   1   qualifies the accepted bundle as the final one of the session
//  op_sel_i     in   3   0 R-type, 1 ADDI, 2 BEQ, 3 BNE, 4 ORI, 5 LUI; 6 and 7 are illegal
//  rs_i,rt_i,rd_i,shamt_i  in  5 each  register and shift fields
//  funct_i      in   6   R-type function field
//  imm_i        in   16  immediate or branch offset
//  mem_we_o     out  1   write request to instruction memory
//  mem_addr_o   out  32  write byte address
//  mem_data_o   out  32  encoded instruction word
//  mem_ready_i  in   1   memory accepts the write on this edge if mem_we_o=1
//  busy_o       out  1   high when state != IDLE
//  done_o       out  1   one-cycle pulse at the end of a session
//  err_o        out  1   sticky illegal-op flag; cleared by an honoured start_i
//  word_cnt_o   out  CNT_W  words written this session; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty; all outputs 0; address and counter registers 0.
//  Encoding:
//    R-type:  {6'h00, rs, rt, rd, shamt, funct}
//    I-type:  {op, rs, rt, imm}; op = 08/04/05/0d/0f
//    LUI:     rs forced to 0
//  FSM: IDLE -> RUN on start_i. In the same edge: mem_addr_o <= base_addr_i, word_cnt_o <= 0, err_o <= 0.
//    RUN -> DRAIN on accepting a bundle with in_last_i=1.
//    DRAIN -> DONE when the FIFO is empty and no write is pending.
//    DONE -> IDLE after 1 cycle; done_o=1 only while in DONE.
//    start_i outside IDLE is ignored.
//  in_ready_o = (state==RUN) & !fifo_full, from registered state only.
//    Illegal op_sel: the handshake completes, nothing is pushed, err_o <= 1.
//    An illegal op with in_last_i=1 still moves the FSM to DRAIN.
//  Output stage: one register holding mem_we_o/mem_data_o.
//    Loads from the FIFO head when it is empty, or when the current write completes on this edge.
//    A write completes on an edge with mem_we_o & mem_ready_i. On completion:
//    mem_addr_o += 4 (wraps modulo 2^32) and word_cnt_o += 1.
//    mem_we_o holds and data/address stay stable while mem_ready_i=0.
//  Latency: a bundle accepted at edge E gives mem_we_o=1 after edge E+1 (FIFO empty, output stage idle).
//  Push and pop on the same edge leave the occupancy unchanged. Full: no push. Empty: no pop.
//  Sustained rate: 1 word per cycle while mem_ready_i=1.
//  Reset mid-session discards the FIFO and any pending write. No partial write is signalled afterwards.
// TESTING
//  T1 start base=0x100; ADDI rs=1 rt=2 imm=0x0005, last.
//     -> one write, addr 0x100, data 0x20220005; done_o pulse; word_cnt=1.
//  T2 R-type rs=1 rt=2 rd=3 funct=0x20, then BNE rs=3 rt=4 imm=0xFFFF, last.
//     -> 0x00221820 @base, 0x1464FFFF @base+4.
//  T3 mem_ready_i=0 for 20 cycles while pushing 10 words.
//     -> in_ready_o drops once 8 words are in the FIFO plus 1 in the output stage.
//     -> All 10 words are written in order with no loss or duplication once ready returns.
//  T4 op_sel=6 between two legal ops.
//     -> err_o=1, 2 words written at consecutive addresses; the next start clears err_o.
//  T5 base=0xFFFFFFFC, 2 words -> addresses 0xFFFFFFFC then 0x00000000.
//  T6 assert rst_i mid-DRAIN (async, between edges).
//     -> all outputs 0 immediately; a new session starts cleanly with word_cnt=0.

Source files
------------

// File: rtl/instr_encoder_writer.sv
// Packs MIPS instruction fields into 32-bit words, buffers them in a FIFO and
// streams them into instruction memory at sequential byte addresses.
module instr_encoder_writer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_last_i,
    input  logic [2:0]       op_sel_i,
    input  logic [4:0]       rs_i,
    input  logic [4:0]       rt_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       shamt_i,
    input  logic [5:0]       funct_i,
    input  logic [15:0]      imm_i,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_o,
    input  logic             mem_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] word_cnt_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;

    logic [31:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        accept, legal, push, pop, wr_done, load;
    logic [31:0] enc_word;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign in_ready_o = (state == RUN) && !fifo_full;
    assign accept     = in_valid_i && in_ready_o;
    assign legal      = (op_sel_i <= 3'd5);
    assign push       = accept && legal;
    assign wr_done    = mem_we_o && mem_ready_i;
    // Output register refills when idle or when its word leaves on this edge.
    assign load       = !mem_we_o || wr_done;
    assign pop        = load && !fifo_empty;

    always_comb begin
        enc_word = 32'h0;
        case (op_sel_i)
            3'd0:    enc_word = {6'h00, rs_i, rt_i, rd_i, shamt_i, funct_i};
            3'd1:    enc_word = {6'h08, rs_i, rt_i, imm_i};
            3'd2:    enc_word = {6'h04, rs_i, rt_i, imm_i};
            3'd3:    enc_word = {6'h05, rs_i, rt_i, imm_i};
            3'd4:    enc_word = {6'h0d, rs_i, rt_i, imm_i};
            3'd5:    enc_word = {6'h0f, 5'd0, rt_i, imm_i};
            default: enc_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= enc_word;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_we_o   <= 1'b0;
            mem_data_o <= 32'h0;
            mem_addr_o <= 32'h0;
            word_cnt_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (accept && !legal) err_o <= 1'b1;

            if (load) begin
                mem_we_o <= pop;
                if (pop) mem_data_o <= fifo_mem[rd_ptr[AW-1:0]];
            end
            if (wr_done) begin
                mem_addr_o <= mem_addr_o + 32'd4;
                word_cnt_o <= word_cnt_o + CNT_W'(1);
            end

            case (state)
                IDLE: if (start_i) begin
                    state      <= RUN;
                    busy_o     <= 1'b1;
                    err_o      <= 1'b0;
                    mem_addr_o <= base_addr_i;
                    word_cnt_o <= '0;
                end
                RUN: if (accept && in_last_i) state <= DRAIN;
                DRAIN: if (fifo_empty && !mem_we_o) begin
                    state  <= DONE;
                    done_o <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
